// File: rtl/latency_pipe_arbiter_pkg.sv
// latency_pipe_arbiter_pkg: shared FSM encoding and width helper for the latency pipe arbiter
package latency_pipe_arbiter_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tag_delay_line.sv
// tag_delay_line: resettable shift register carrying {vld,id} in step with the datapath
module tag_delay_line #(
    parameter int LATENCY = 3,
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] d,
    output logic [TW-1:0] q
);
    localparam int SW = LATENCY * TW;
    logic [SW-1:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else sr <= (sr << TW) | SW'(d);
    assign q = sr[SW-1 -: TW];
endmodule

// File: rtl/latency_pipe_arbiter.sv
// latency_pipe_arbiter: round-robin sharing of a fixed-latency datapath with tag-steered responses
module latency_pipe_arbiter
    import latency_pipe_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32,
    parameter int LATENCY = 3,
    localparam int IW = id_width(N),
    localparam int CW = id_width(LATENCY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]  req_ready,
    output logic [W-1:0]  dp_in,
    output logic          dp_in_vld,
    input  logic [W-1:0]  dp_out,
    output logic [N-1:0]  rsp_valid,
    output logic [W-1:0]  rsp_data,
    input  logic          flush,
    output logic          idle,
    output logic [CW-1:0] inflight
);
    state_t state, state_nxt;
    logic [IW-1:0] ptr, gnt_id, rsp_id;
    logic [IW:0] tag_q;
    logic gnt, grant_en, rsp_v, rst_done;
    logic [CW-1:0] cnt_nxt;

    // rst_done keeps grants off until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= RUN;
            rst_done <= 1'b0;
        end else begin
            state <= state_nxt;
            rst_done <= 1'b1;
        end

    always_comb begin
        cnt_nxt = inflight + CW'(gnt) - CW'(rsp_v);
        state_nxt = !flush ? RUN : (state == RUN) ? DRAIN : (state == HALT || cnt_nxt == '0) ? HALT : DRAIN;
    end

    always_comb begin
        grant_en = rst_done && state == RUN && !flush;
        idle = !rst_done || ((state != RUN || !(|req_valid)) && inflight == '0);
    end

    // descending scan so the closest index at or after ptr wins
    always_comb begin
        gnt = 1'b0;
        gnt_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            automatic logic [IW-1:0] j = IW'((int'(ptr) + k) % N);
            if (req_valid[j]) begin
                gnt = grant_en;
                gnt_id = j;
            end
        end
    end

    always_comb begin
        dp_in = '0;
        for (int i = 0; i < N; i++)
            if (gnt && gnt_id == IW'(i)) dp_in = req_data[i*W +: W];
        req_ready = gnt ? N'(1) << gnt_id : '0;
        dp_in_vld = gnt;
        rsp_valid = rsp_v ? N'(1) << rsp_id : '0;
        rsp_data = dp_out;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr <= '0;
            inflight <= '0;
        end else begin
            if (gnt) ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
            inflight <= cnt_nxt;
        end

    tag_delay_line #(.LATENCY(LATENCY), .TW(IW + 1)) u_tags (
        .clk(clk),
        .rst_n(rst_n),
        .d({gnt, gnt_id}),
        .q(tag_q)
    );
    assign rsp_v = tag_q[IW];
    assign rsp_id = tag_q[IW-1:0];
endmodule

// File: tb/tb_latency_pipe_arbiter.sv
// tb_latency_pipe_arbiter: scoreboard bench driving LATENCY=3 and LATENCY=1 builds with shared requests
module tb_latency_pipe_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic flush = 1'b0;
    logic [N-1:0] req_ready0, rsp_valid0, req_ready1, rsp_valid1;
    logic [W-1:0] dp_in0, dp_out0, rsp_data0, dp_in1, dp_out1, rsp_data1;
    logic dp_in_vld0, idle0, dp_in_vld1, idle1;
    logic [1:0] inflight0;
    logic inflight1;

    typedef struct {int id; logic [W-1:0] data; int due;} exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int cyc = 0;
    int checks = 0;
    int fails = 0;
    logic [N-1:0] ev;
    logic [W-1:0] d, prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] pipe0 [3];
    logic [W-1:0] pipe1;
    always @(posedge clk) begin
        pipe0[0] <= dp_in0;
        pipe0[1] <= pipe0[0];
        pipe0[2] <= pipe0[1];
        pipe1 <= dp_in1;
    end
    assign dp_out0 = pipe0[2];
    assign dp_out1 = pipe1;

    latency_pipe_arbiter #(.N(N), .W(W), .LATENCY(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready0), .dp_in(dp_in0), .dp_in_vld(dp_in_vld0), .dp_out(dp_out0),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .flush(flush), .idle(idle0), .inflight(inflight0)
    );
    latency_pipe_arbiter #(.N(N), .W(W), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready1), .dp_in(dp_in1), .dp_in_vld(dp_in_vld1), .dp_out(dp_out1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .flush(flush), .idle(idle1), .inflight(inflight1)
    );

    // response scoreboard for both builds
    always @(negedge clk) if (rst_n) begin
        checks++;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            ev = 4'b1 << q0[0].id;
            if (rsp_valid0 !== ev || rsp_data0 !== q0[0].data) begin
                fails++;
                $display("FAIL rsp0 cyc %0d: got %b/%h want %b/%h", cyc, rsp_valid0, rsp_data0, ev, q0[0].data);
            end
            void'(q0.pop_front());
        end else if (rsp_valid0 !== 4'b0) begin
            fails++;
            $display("FAIL rsp0_idle cyc %0d: got %b want 0000", cyc, rsp_valid0);
        end
        checks++;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev = 4'b1 << q1[0].id;
            if (rsp_valid1 !== ev || rsp_data1 !== q1[0].data) begin
                fails++;
                $display("FAIL rsp1 cyc %0d: got %b/%h want %b/%h", cyc, rsp_valid1, rsp_data1, ev, q1[0].data);
            end
            void'(q1.pop_front());
        end else if (rsp_valid1 !== 4'b0) begin
            fails++;
            $display("FAIL rsp1_idle cyc %0d: got %b want 0000", cyc, rsp_valid1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input int id, input logic [W-1:0] data);
        q0.push_back('{id, data, cyc + 3});
        q1.push_back('{id, data, cyc + 1});
    endtask

    task automatic check_ready(input string name, input logic [N-1:0] want);
        checks++;
        if (req_ready0 !== want) begin
            fails++;
            $display("FAIL %s cyc %0d: req_ready got %b want %b", name, cyc, req_ready0, want);
        end
    endtask

    task automatic test_reset();
        req_valid = 4'hf;
        @(negedge clk);
        checks++;
        if (req_ready0 !== 4'b0 || dp_in_vld0 !== 1'b0 || rsp_valid0 !== 4'b0 || idle0 !== 1'b1 || inflight0 !== 2'd0 || req_ready1 !== 4'b0) begin
            fails++;
            $display("FAIL reset_state: ready %b vld %b rsp %b idle %b inflight %0d want 0000 0 0000 1 0", req_ready0, dp_in_vld0, rsp_valid0, idle0, inflight0);
        end
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready0 !== 4'b0 || idle0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: ready %b idle %b want 0000 1", req_ready0, idle0);
        end
        step();
    endtask

    task automatic test_all_valid();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            d = req_data[(k % 4)*W +: W];
            @(negedge clk);
            check_ready("all_valid", 4'b1 << (k % 4));
            checks++;
            if (dp_in0 !== d || dp_in_vld0 !== 1'b1 || inflight0 !== 2'(k < 3 ? k : 3)) begin
                fails++;
                $display("FAIL all_valid_dp k %0d: dp %h vld %b inflight %0d want %h 1 %0d", k, dp_in0, dp_in_vld0, inflight0, d, k < 3 ? k : 3);
            end
            push(k % 4, d);
            step();
        end
        req_valid = '0;
        idle_cycles(4);
    endtask

    task automatic test_single();
        req_valid = 4'b0010;
        req_data = '0;
        req_data[W +: W] = 32'hA5;
        @(negedge clk);
        check_ready("single_grant", 4'b0010);
        checks++;
        if (dp_in0 !== 32'hA5) begin
            fails++;
            $display("FAIL single_dp: got %h want 000000a5", dp_in0);
        end
        push(1, 32'hA5);
        step();
        req_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid0 !== (k == 3 ? 4'b0010 : 4'b0000) || (k == 3 && rsp_data0 !== 32'hA5)) begin
                fails++;
                $display("FAIL single_rsp t+%0d: got %b/%h want %b/000000a5", k, rsp_valid0, rsp_data0, k == 3 ? 4'b0010 : 4'b0000);
            end
            step();
        end
    endtask

    task automatic test_fairness();
        req_valid = 4'b0001;
        d = $urandom;
        req_data[0 +: W] = d;
        @(negedge clk);
        check_ready("fair_setup", 4'b0001);
        push(0, d);
        step();
        req_valid = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            d = req_data[(k % 2 == 0 ? 3 : 0)*W +: W];
            @(negedge clk);
            check_ready("fairness", k % 2 == 0 ? 4'b1000 : 4'b0001);
            push(k % 2 == 0 ? 3 : 0, d);
            step();
        end
        req_valid = '0;
        idle_cycles(4);
    endtask

    task automatic test_flush();
        req_valid = 4'hf;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            d = req_data[(k + 1)*W +: W];
            @(negedge clk);
            check_ready("flush_fill", 4'b1 << (k + 1));
            push(k + 1, d);
            step();
        end
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_ready("flush_block", 4'b0);
            checks++;
            if (dp_in_vld0 !== 1'b0 || idle0 !== 1'b0 || inflight0 !== 2'(3 - k)) begin
                fails++;
                $display("FAIL flush_drain k %0d: vld %b idle %b inflight %0d want 0 0 %0d", k, dp_in_vld0, idle0, inflight0, 3 - k);
            end
            step();
        end
        @(negedge clk);
        check_ready("flush_halt", 4'b0);
        checks++;
        if (idle0 !== 1'b1 || inflight0 !== 2'd0) begin
            fails++;
            $display("FAIL flush_idle: idle %b inflight %0d want 1 0", idle0, inflight0);
        end
        step();
        flush = 1'b0;
        @(negedge clk);
        check_ready("flush_release", 4'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            d = req_data[k*W +: W];
            @(negedge clk);
            check_ready("flush_resume", 4'b1 << k);
            push(k, d);
            step();
        end
        req_valid = '0;
        idle_cycles(4);
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            req_data[2*W +: W] = d;
            @(negedge clk);
            check_ready("mid_fill", 4'b0100);
            push(2, d);
            step();
        end
        rst_n = 1'b0;
        req_valid = 4'hf;
        q0.delete();
        q1.delete();
        @(negedge clk);
        checks++;
        if (rsp_valid0 !== 4'b0 || inflight0 !== 2'd0 || req_ready0 !== 4'b0) begin
            fails++;
            $display("FAIL mid_reset: rsp %b inflight %0d ready %b want 0000 0 0000", rsp_valid0, inflight0, req_ready0);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_ready("mid_release", 4'b0);
        step();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
        d = req_data[0 +: W];
        @(negedge clk);
        check_ready("mid_ptr_zero", 4'b0001);
        push(0, d);
        step();
        req_valid = '0;
        idle_cycles(5);
    endtask

    task automatic test_latency1();
        req_valid = 4'b0100;
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            req_data[2*W +: W] = d;
            @(negedge clk);
            checks++;
            if (req_ready1 !== 4'b0100 || rsp_valid1 !== (k > 0 ? 4'b0100 : 4'b0000) || (k > 0 && rsp_data1 !== prev)) begin
                fails++;
                $display("FAIL lat1_b2b k %0d: ready %b rsp %b/%h want 0100 %b/%h", k, req_ready1, rsp_valid1, rsp_data1, k > 0 ? 4'b0100 : 4'b0000, prev);
            end
            push(2, d);
            prev = d;
            step();
        end
        req_valid = '0;
        idle_cycles(4);
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_single();
        test_fairness();
        test_flush();
        test_reset_mid();
        test_latency1();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: left %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
